// File: rtl/uart_pkg.sv
// Framing constants shared by the UART frame parser and the matching frame transmitter.
// Frame layout on the wire: SYNC, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
package uart_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;
    localparam int unsigned TIMEOUT_CLKS_DEFAULT = 17360;
    localparam int unsigned FRAME_MAX_LEN        = 16;
    localparam int unsigned FRAME_HDR_BYTES      = 2;  // SYNC, LEN
    localparam int unsigned FRAME_TRL_BYTES      = 1;  // CHK

    function automatic logic [7:0] frame_chk_step(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 registers, one synchronous write port,
// one combinational read port. Contents are not reset.
module uart_frame_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind uart_rx: checks SYNC/LEN/payload/CHK, buffers a good payload
// and streams it out on a valid/ready byte port. MAX_LEN must stay below 256.
//
//   state     | meaning
//   S_HUNT    | waiting for SYNC_BYTE, other bytes dropped
//   S_LEN     | next byte is the payload length
//   S_PAYLOAD | storing payload bytes, accumulating checksum
//   S_CHK     | next byte is compared against the checksum
//   S_DRAIN   | presenting buffered payload, incoming bytes are overruns
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter  int unsigned MAX_LEN      = FRAME_MAX_LEN,
    parameter  logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter  int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT,
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1)
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Rx_DV,
    input  logic [7:0]       i_Rx_Byte,
    output logic [7:0]       o_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic             o_Last,
    output logic [LEN_W-1:0] o_Len,
    output logic             o_Len_Err,
    output logic             o_Chk_Err,
    output logic             o_Timeout_Err,
    output logic             o_Overrun,
    output logic             o_Busy
);

    localparam int unsigned      BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned      TMR_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [LEN_W-1:0] idx, idx_nxt;
    logic [LEN_W-1:0] rd_idx, rd_idx_nxt;
    logic [7:0]       chk, chk_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             len_err_q, chk_err_q, tmo_err_q, ovr_q;
    logic             len_err_nxt, chk_err_nxt, tmo_err_nxt, ovr_nxt;
    logic             buf_we;
    logic [7:0]       rd_data;
    logic             tmr_tc;
    logic             last;
    logic             handshake;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (BUF_AW)
    ) u_buf (
        .i_Clock (i_Clock),
        .wr_en   (buf_we),
        .wr_addr (idx[BUF_AW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_idx[BUF_AW-1:0]),
        .rd_data (rd_data)
    );

    assign tmr_tc    = (tmr == '0);
    assign last      = (rd_idx == len - LEN_ONE);
    assign handshake = (state == S_DRAIN) && i_Ready;

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        idx_nxt     = idx;
        rd_idx_nxt  = rd_idx;
        chk_nxt     = chk;
        tmr_nxt     = tmr;
        buf_we      = 1'b0;
        len_err_nxt = 1'b0;
        chk_err_nxt = 1'b0;
        tmo_err_nxt = 1'b0;
        ovr_nxt     = 1'b0;

        if (state inside {S_LEN, S_PAYLOAD, S_CHK}) begin
            tmr_nxt = tmr - TMR_W'(1);
        end

        case (state)
            S_HUNT: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end else begin
                        len_nxt   = i_Rx_Byte[LEN_W-1:0];
                        chk_nxt   = i_Rx_Byte;
                        idx_nxt   = '0;
                        state_nxt = S_PAYLOAD;
                    end
                end else if (tmr_tc) begin
                    tmo_err_nxt = 1'b1;
                    state_nxt   = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    buf_we  = 1'b1;
                    chk_nxt = frame_chk_step(chk, i_Rx_Byte);
                    // idx stays at len-1 on the last byte so it never exceeds MAX_LEN-1
                    if (idx == len - LEN_ONE) begin
                        state_nxt = S_CHK;
                    end else begin
                        idx_nxt = idx + LEN_ONE;
                    end
                end else if (tmr_tc) begin
                    tmo_err_nxt = 1'b1;
                    state_nxt   = S_HUNT;
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk) begin
                        rd_idx_nxt = '0;
                        state_nxt  = S_DRAIN;
                    end else begin
                        chk_err_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end
                end else if (tmr_tc) begin
                    tmo_err_nxt = 1'b1;
                    state_nxt   = S_HUNT;
                end
            end
            S_DRAIN: begin
                ovr_nxt = i_Rx_DV;
                if (handshake) begin
                    if (last) begin
                        state_nxt = S_HUNT;
                    end else begin
                        rd_idx_nxt = rd_idx + LEN_ONE;
                    end
                end
            end
            default: begin
                state_nxt = S_HUNT;
            end
        endcase

        // A byte on the expiry cycle reloads here, so the byte wins over the timeout
        if (i_Rx_DV || state_nxt != state) begin
            tmr_nxt = TMR_LOAD;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_HUNT;
            len       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            chk       <= '0;
            tmr       <= TMR_LOAD;
            len_err_q <= 1'b0;
            chk_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            rd_idx    <= rd_idx_nxt;
            chk       <= chk_nxt;
            tmr       <= tmr_nxt;
            len_err_q <= len_err_nxt;
            chk_err_q <= chk_err_nxt;
            tmo_err_q <= tmo_err_nxt;
            ovr_q     <= ovr_nxt;
        end
    end

    // Outputs are forced low while reset is held, even before the reset edge lands
    assign o_Valid       = (state == S_DRAIN) && !i_Reset;
    assign o_Data        = o_Valid ? rd_data : 8'd0;
    assign o_Last        = o_Valid && last;
    assign o_Len         = o_Valid ? len : '0;
    assign o_Busy        = (state != S_HUNT) && !i_Reset;
    assign o_Len_Err     = len_err_q && !i_Reset;
    assign o_Chk_Err     = chk_err_q && !i_Reset;
    assign o_Timeout_Err = tmo_err_q && !i_Reset;
    assign o_Overrun     = ovr_q && !i_Reset;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: directed and random byte streams, a frame-level
// reference parser feeding a scoreboard, and a monitor checking beats and pulses.
module tb_uart_rx_frame_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 16;
    localparam int         TCLK = 17360;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [4:0] n;
    } beat_t;

    logic       i_Clock;
    logic       i_Reset;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       i_Ready;
    logic       o_Last;
    logic [4:0] o_Len;
    logic       o_Len_Err;
    logic       o_Chk_Err;
    logic       o_Timeout_Err;
    logic       o_Overrun;
    logic       o_Busy;

    int    checks      = 0;
    int    errors      = 0;
    int    exp_len_err = 0;
    int    exp_chk_err = 0;
    int    exp_tmo     = 0;
    int    exp_ovr     = 0;
    int    rdy_mode    = 0;
    beat_t exp_q[$];
    logic [7:0] stim[$];

    uart_rx_frame_parser dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Rx_DV       (i_Rx_DV),
        .i_Rx_Byte     (i_Rx_Byte),
        .o_Data        (o_Data),
        .o_Valid       (o_Valid),
        .i_Ready       (i_Ready),
        .o_Last        (o_Last),
        .o_Len         (o_Len),
        .o_Len_Err     (o_Len_Err),
        .o_Chk_Err     (o_Chk_Err),
        .o_Timeout_Err (o_Timeout_Err),
        .o_Overrun     (o_Overrun),
        .o_Busy        (o_Busy)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // consumer: random, toggling, or always-ready
    initial begin
        i_Ready = 1'b0;
        forever begin
            @(posedge i_Clock); #1;
            case (rdy_mode)
                0:       i_Ready = ($urandom_range(0, 3) != 0);
                1:       i_Ready = ~i_Ready;
                default: i_Ready = 1'b1;
            endcase
        end
    end

    // frame-level reference: walks a byte stream sent to an idle parser
    task automatic model_stream(input logic [7:0] s[$]);
        int i;
        int n;
        logic [7:0] c;
        beat_t b;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
            end else if (i + 1 >= s.size()) begin
                i = s.size();
            end else begin
                n = int'(s[i+1]);
                if (n == 0 || n > MAXL) begin
                    exp_len_err++;
                    i += 2;
                end else if (i + 2 + n >= s.size()) begin
                    i = s.size();
                end else begin
                    c = s[i+1];
                    for (int k = 0; k < n; k++) c = c ^ s[i+2+k];
                    if (s[i+2+n] == c) begin
                        for (int k = 0; k < n; k++) begin
                            b.d = s[i+2+k];
                            b.l = (k == n - 1);
                            b.n = 5'(n);
                            exp_q.push_back(b);
                        end
                    end else begin
                        exp_chk_err++;
                    end
                    i += 3 + n;
                end
            end
        end
    endtask

    task automatic chk_pulse(input logic p, input logic was, input string nm, inout int pend);
        if (p === 1'b1) begin
            checks++;
            if (was) begin
                errors++;
                $display("FAIL %s width: high 2 cycles, required 1", nm);
            end else if (pend > 0) begin
                pend--;
            end else begin
                errors++;
                $display("FAIL %s unexpected: got 1, required 0 (none pending)", nm);
            end
        end
    endtask

    // monitor / scoreboard
    initial begin
        beat_t b;
        logic hold;
        logic [7:0] h_d;
        logic h_l;
        logic [4:0] h_n;
        logic [3:0] prev;
        hold = 1'b0; h_d = '0; h_l = 1'b0; h_n = '0; prev = '0;
        forever begin
            @(negedge i_Clock);
            if (i_Reset) begin
                hold = 1'b0;
                prev = '0;
            end else begin
                if (hold) begin
                    checks++;
                    if (o_Valid !== 1'b1 || o_Data !== h_d || o_Last !== h_l || o_Len !== h_n) begin
                        errors++;
                        $display("FAIL hold: valid=%0b data=%02h last=%0b len=%0d required valid=1 data=%02h last=%0b len=%0d",
                                 o_Valid, o_Data, o_Last, o_Len, h_d, h_l, h_n);
                    end
                end
                if (o_Valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: data=%02h, required no output", o_Data);
                    end else if (i_Ready) begin
                        b = exp_q.pop_front();
                        checks++;
                        if (o_Data !== b.d || o_Last !== b.l || o_Len !== b.n) begin
                            errors++;
                            $display("FAIL beat: data=%02h last=%0b len=%0d required data=%02h last=%0b len=%0d",
                                     o_Data, o_Last, o_Len, b.d, b.l, b.n);
                        end
                    end
                end
                hold = o_Valid && !i_Ready;
                h_d  = o_Data;
                h_l  = o_Last;
                h_n  = o_Len;
                chk_pulse(o_Len_Err,     prev[0], "len_err", exp_len_err);
                chk_pulse(o_Chk_Err,     prev[1], "chk_err", exp_chk_err);
                chk_pulse(o_Timeout_Err, prev[2], "timeout", exp_tmo);
                chk_pulse(o_Overrun,     prev[3], "overrun", exp_ovr);
                prev = {o_Overrun, o_Timeout_Err, o_Chk_Err, o_Len_Err};
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_Clock); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(posedge i_Clock); #1;
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge i_Clock);
        while ((o_Busy || exp_q.size() != 0) && n < 400) begin
            @(negedge i_Clock);
            n++;
        end
        checks++;
        if (o_Busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s idle: busy=%0b pending=%0d after %0d cycles, required busy=0 pending=0",
                     nm, o_Busy, exp_q.size(), n);
        end
        @(posedge i_Clock); #1;
    endtask

    task automatic run_stream(input logic [7:0] s[$], input string nm);
        model_stream(s);
        foreach (s[k]) begin
            send_byte(s[k]);
            idle($urandom_range(0, 2));
        end
        wait_idle(nm);
    endtask

    task automatic load_stim(input logic [127:0] v, input int n);
        stim.delete();
        for (int k = 0; k < n; k++) stim.push_back(v[8*(n-1-k) +: 8]);
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({o_Valid, o_Busy, o_Last, o_Data, o_Len, o_Len_Err, o_Chk_Err, o_Timeout_Err, o_Overrun} !== '0) begin
            errors++;
            $display("FAIL %s outputs: valid=%0b busy=%0b last=%0b data=%02h len=%0d errs=%0b%0b%0b%0b required all 0",
                     nm, o_Valid, o_Busy, o_Last, o_Data, o_Len, o_Len_Err, o_Chk_Err, o_Timeout_Err, o_Overrun);
        end
    endtask

    initial begin
        int         n;
        int         kind;
        logic [7:0] b;
        logic [7:0] c;

        i_Reset   = 1'b1;
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        check_zero("reset");
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        idle(2);

        // 1: garbage then a good 3-byte frame
        load_stim(128'h00FFA50311223303, 8);
        run_stream(stim, "t1");

        // 2: bad checksum, then a good frame
        load_stim(128'hA502AA5500, 5);
        run_stream(stim, "t2_bad");
        load_stim(128'hA502AA55FD, 5);
        run_stream(stim, "t2_good");

        // 3: LEN of 0 and of MAX_LEN+1
        load_stim(128'hA500A511, 4);
        run_stream(stim, "t3");

        // 4: toggling ready, stray byte during drain
        rdy_mode = 1;
        load_stim(128'hA50311223303, 6);
        model_stream(stim);
        foreach (stim[k]) send_byte(stim[k]);
        idle(1);
        exp_ovr++;
        send_byte(8'h77);
        wait_idle("t4");

        // SYNC on the final handshake cycle is lost as an overrun
        rdy_mode = 2;
        idle(2);
        load_stim(128'hA50311223303, 6);
        model_stream(stim);
        foreach (stim[k]) send_byte(stim[k]);
        idle(2);
        exp_ovr++;
        send_byte(SYNC);
        load_stim(128'h0311223303, 5);
        foreach (stim[k]) send_byte(stim[k]);
        wait_idle("t4_last_hs");
        rdy_mode = 0;

        // 5: timeout after an idle gap, exact expiry cycle
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'hAA);
        exp_tmo++;
        idle(TCLK - 1);
        @(negedge i_Clock);
        checks++;
        if (o_Timeout_Err !== 1'b0) begin
            errors++;
            $display("FAIL t5_early: timeout=%0b required 0", o_Timeout_Err);
        end
        @(posedge i_Clock); #1;
        @(negedge i_Clock);
        checks++;
        if (o_Timeout_Err !== 1'b1) begin
            errors++;
            $display("FAIL t5_expiry: timeout=%0b required 1", o_Timeout_Err);
        end
        wait_idle("t5_tmo");
        load_stim(128'hA50311223303, 6);
        run_stream(stim, "t5_after");

        load_stim(128'hA502AA55FD, 5);
        model_stream(stim);
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'hAA);
        idle(TCLK - 1);
        send_byte(8'h55);
        send_byte(8'hFD);
        wait_idle("t5_exact");

        // 6: reset in the middle of a frame
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        check_zero("t6_reset");
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        load_stim(128'h223303, 3);
        foreach (stim[k]) send_byte(stim[k]);
        wait_idle("t6_tail");
        load_stim(128'h00FFA50311223303, 8);
        run_stream(stim, "t6_frame");

        // random frames: garbage prefix, then good / bad-CHK / bad-LEN
        for (int f = 0; f < 40; f++) begin
            stim.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                stim.push_back(b);
            end
            stim.push_back(SYNC);
            kind = $urandom_range(0, 9);
            if (kind == 0 && f > 1) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
                stim.push_back(8'(n));
            end else begin
                n = (f == 0) ? MAXL : (f == 1) ? 1 : $urandom_range(1, MAXL);
                stim.push_back(8'(n));
                c = 8'(n);
                for (int k = 0; k < n; k++) begin
                    b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
                    stim.push_back(b);
                    c = c ^ b;
                end
                if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
                stim.push_back(c);
            end
            run_stream(stim, "rand");
        end

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL end_beats: pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (exp_len_err != 0 || exp_chk_err != 0 || exp_tmo != 0 || exp_ovr != 0) begin
            errors++;
            $display("FAIL end_pulses: missing len=%0d chk=%0d tmo=%0d ovr=%0d required all 0",
                     exp_len_err, exp_chk_err, exp_tmo, exp_ovr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
